// File: rtl/pwm_dac_pkg.sv
// pwm_dac_pkg: shared types and helpers for the PWM audio DAC.
//
// Contents:
//   pwm_dir_t          counter direction state (used by the centre-aligned build)
//   CENTER_ALIGNED     1 when PWM_DAC_CENTER_ALIGNED_EN is defined, else 0
//   pwm_period_len(n)  PWM period in enabled clock cycles for an n-bit counter
//
// Build option: PWM_DAC_CENTER_ALIGNED_EN selects an up/down (centre-aligned)
// counter. When it is undefined the counter is a plain edge-aligned up counter.

package pwm_dac_pkg;

    typedef enum logic {
        COUNT_UP   = 1'b0,
        COUNT_DOWN = 1'b1
    } pwm_dir_t;

`ifdef PWM_DAC_CENTER_ALIGNED_EN
    localparam bit CENTER_ALIGNED = 1'b1;
`else
    localparam bit CENTER_ALIGNED = 1'b0;
`endif

    // Up 0..2^n-1 then down 2^n-2..1 in centre-aligned mode; plain 2^n otherwise.
    function automatic int unsigned pwm_period_len(input int unsigned n);
        int unsigned full_s;
        full_s = 32'd1 << n;
        if (CENTER_ALIGNED) begin
            return (full_s << 1) - 32'd2;
        end else begin
            return full_s;
        end
    endfunction

endpackage

// File: rtl/pwm_period_counter.sv
// pwm_period_counter: PWM frame counter for pwm_dac.
//
// Ports:
//   clk   in   system clock, all state on posedge
//   rst   in   asynchronous active-low reset
//   ena   in   advances the counter; the counter holds while low
//   cnt   out  current counter value (registered)
//   wrap  out  frame-boundary strobe: high on the enabled cycle whose edge
//              starts the next period
//
// Build option PWM_DAC_CENTER_ALIGNED_EN: counter runs 0..2^N-1 up, then
// 2^N-2..1 down, with the direction kept in a one-bit state register; wrap
// fires on the down-count value 1. Without the macro it is a wrapping up
// counter and wrap fires at 2^N-1.

module pwm_period_counter
    import pwm_dac_pkg::*;
#(
    parameter int N = 8
)
(
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    output logic [N-1:0] cnt,
    output logic         wrap
);

    localparam logic [N-1:0] CNT_MAX  = {N{1'b1}};
    localparam logic [N-1:0] CNT_ZERO = {N{1'b0}};
    localparam logic [N-1:0] CNT_ONE  = {{(N-1){1'b0}}, 1'b1};

    logic [N-1:0] cnt_q;
    logic [N-1:0] cnt_d;

`ifdef PWM_DAC_CENTER_ALIGNED_EN
    pwm_dir_t dir_q;
    pwm_dir_t dir_d;

    // Next count and direction: turn around at the top, restart from 0 after 1.
    always_comb begin
        cnt_d = cnt_q;
        dir_d = dir_q;
        if (ena) begin
            case (dir_q)
                COUNT_UP: begin
                    if (cnt_q == CNT_MAX) begin
                        dir_d = COUNT_DOWN;
                        cnt_d = cnt_q - CNT_ONE;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                COUNT_DOWN: begin
                    if (cnt_q == CNT_ONE) begin
                        dir_d = COUNT_UP;
                        cnt_d = CNT_ZERO;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    dir_d = COUNT_UP;
                    cnt_d = CNT_ZERO;
                end
            endcase
        end else begin
            cnt_d = cnt_q;
            dir_d = dir_q;
        end
    end

    // Counter and direction state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= CNT_ZERO;
            dir_q <= COUNT_UP;
        end else begin
            cnt_q <= cnt_d;
            dir_q <= dir_d;
        end
    end

    assign wrap = ena && (dir_q == COUNT_DOWN) && (cnt_q == CNT_ONE);
`else
    // Next count: free-running up counter that wraps naturally at 2^N.
    always_comb begin
        cnt_d = cnt_q;
        if (ena) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= CNT_ZERO;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign wrap = ena && (cnt_q == CNT_MAX);
`endif

    assign cnt = cnt_q;

endmodule

// File: rtl/pwm_dac.sv
// pwm_dac: consumes N-bit unsigned samples over valid/ready and plays them
// out as a 1-bit PWM signal, one sample per PWM period.
//
// Ports:
//   clk           in   system clock, all state on posedge
//   rst           in   asynchronous active-low reset
//   ena           in   advances the PWM; counter and pwm_out freeze while low
//   sample_in     in   unsigned sample, duty = sample_in / 2^N
//   sample_valid  in   sample_in carries a sample
//   sample_ready  out  a sample can be taken this cycle
//   underrun_clr  in   clears the sticky underrun flag
//   pwm_out       out  registered PWM bit
//   period_start  out  registered one-cycle pulse with the first bit of a period
//   underrun      out  sticky: a period boundary found no sample waiting
//
// A one-deep pending register absorbs samples between frame boundaries; the
// duty register only reloads at a boundary, so a period is never split.
// Build option PWM_DAC_CENTER_ALIGNED_EN switches pwm_period_counter to
// centre-aligned counting; this file is identical in both builds.

module pwm_dac
    import pwm_dac_pkg::*;
#(
    parameter int N = 8
)
(
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic [N-1:0] sample_in,
    input  logic         sample_valid,
    output logic         sample_ready,
    input  logic         underrun_clr,
    output logic         pwm_out,
    output logic         period_start,
    output logic         underrun
);

    localparam logic [N-1:0] ZERO_N = {N{1'b0}};

    logic [N-1:0] cnt_s;
    logic         wrap_s;
    logic         xfer_s;

    logic [N-1:0] duty_q,         duty_d;
    logic [N-1:0] pending_q,      pending_d;
    logic         pending_full_q, pending_full_d;
    logic         pwm_q,          pwm_d;
    logic         period_start_q, period_start_d;
    logic         underrun_q,     underrun_d;

    pwm_period_counter #(
        .N (N)
    ) u_counter (
        .clk  (clk),
        .rst  (rst),
        .ena  (ena),
        .cnt  (cnt_s),
        .wrap (wrap_s)
    );

    // While a sample is pending, the generator is held off; that includes the
    // boundary cycle that drains pending, so refill starts one cycle later.
    assign sample_ready = ~pending_full_q;
    assign xfer_s       = sample_valid && !pending_full_q;

    // Sample path: fill pending off-boundary; at a boundary load duty from
    // pending, or straight from the input when pending is empty (bypass).
    always_comb begin
        duty_d         = duty_q;
        pending_d      = pending_q;
        pending_full_d = pending_full_q;
        if (wrap_s) begin
            if (pending_full_q) begin
                duty_d         = pending_q;
                pending_full_d = 1'b0;
            end else if (xfer_s) begin
                duty_d = sample_in;
            end else begin
                duty_d = duty_q;
            end
        end else if (xfer_s) begin
            pending_d      = sample_in;
            pending_full_d = 1'b1;
        end else begin
            pending_full_d = pending_full_q;
        end
    end

    // Underrun flag: a starved boundary sets it and beats a same-cycle clear.
    always_comb begin
        underrun_d = underrun_q;
        if (wrap_s && !pending_full_q && !xfer_s) begin
            underrun_d = 1'b1;
        end else if (underrun_clr) begin
            underrun_d = 1'b0;
        end else begin
            underrun_d = underrun_q;
        end
    end

    // Compare stage: uses the pre-edge count, so pwm_out lags cnt by a cycle.
    always_comb begin
        pwm_d          = pwm_q;
        period_start_d = 1'b0;
        if (ena) begin
            pwm_d          = (cnt_s < duty_q);
            period_start_d = (cnt_s == ZERO_N);
        end else begin
            pwm_d          = pwm_q;
            period_start_d = 1'b0;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            duty_q         <= ZERO_N;
            pending_q      <= ZERO_N;
            pending_full_q <= 1'b0;
            pwm_q          <= 1'b0;
            period_start_q <= 1'b0;
            underrun_q     <= 1'b0;
        end else begin
            duty_q         <= duty_d;
            pending_q      <= pending_d;
            pending_full_q <= pending_full_d;
            pwm_q          <= pwm_d;
            period_start_q <= period_start_d;
            underrun_q     <= underrun_d;
        end
    end

    assign pwm_out      = pwm_q;
    assign period_start = period_start_q;
    assign underrun     = underrun_q;

endmodule

// File: tb/tb_pwm_dac.sv
// tb_pwm_dac: self-checking bench for pwm_dac (edge-aligned build, N=4).
// A cycle model predicts every output; predictions go through a queue and are
// compared one cycle later. Duties loaded at each boundary go into a second
// queue and are compared with the measured high count of each finished period.

module tb_pwm_dac;

    localparam int N = 4;
    localparam logic [N-1:0] CMAX = 4'd15;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         ena = 1'b0;
    logic [N-1:0] sample_in = 4'd0;
    logic         sample_valid = 1'b0;
    logic         sample_ready;
    logic         underrun_clr = 1'b0;
    logic         pwm_out;
    logic         period_start;
    logic         underrun;

    always #5 clk = ~clk;

    pwm_dac #(.N(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .ena          (ena),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .underrun_clr (underrun_clr),
        .pwm_out      (pwm_out),
        .period_start (period_start),
        .underrun     (underrun)
    );

    typedef struct packed {
        logic pwm;
        logic ps;
        logic und;
    } exp_t;

    exp_t exp_q[$];
    int   period_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    logic [N-1:0] m_cnt, m_duty, m_pend;
    logic         m_full, m_pwm, m_und;

    int cur_highs  = 0;
    int last_highs = 0;
    int n_starts   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clock: predict, push, clock, pop and compare, then track periods.
    task automatic step();
        exp_t e;
        logic xfer, wrap, edge_ena;
        int   d;
        n_checks++;
        if (sample_ready !== ~m_full) begin
            n_fail++;
            $display("FAIL sample_ready: got %b, expected %b", sample_ready, ~m_full);
        end
        xfer     = sample_valid && !m_full;
        wrap     = ena && (m_cnt == CMAX);
        edge_ena = ena;
        e.pwm = ena ? (m_cnt < m_duty) : m_pwm;
        e.ps  = ena && (m_cnt == 4'd0);
        e.und = (wrap && !m_full && !xfer) ? 1'b1 : (underrun_clr ? 1'b0 : m_und);
        if (wrap) begin
            if (m_full) begin
                m_duty = m_pend;
                m_full = 1'b0;
            end else if (xfer) begin
                m_duty = sample_in;
            end
            period_q.push_back(int'(m_duty));
        end else if (xfer) begin
            m_pend = sample_in;
            m_full = 1'b1;
        end
        if (ena) m_cnt = m_cnt + 4'd1;
        m_pwm = e.pwm;
        m_und = e.und;
        exp_q.push_back(e);

        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        n_checks += 3;
        if (pwm_out !== e.pwm) begin
            n_fail++;
            $display("FAIL pwm_out: got %b, expected %b", pwm_out, e.pwm);
        end
        if (period_start !== e.ps) begin
            n_fail++;
            $display("FAIL period_start: got %b, expected %b", period_start, e.ps);
        end
        if (underrun !== e.und) begin
            n_fail++;
            $display("FAIL underrun: got %b, expected %b", underrun, e.und);
        end

        if (period_start === 1'b1) begin
            if (n_starts > 0) begin
                if (period_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL period_highs: got %0d, expected <none queued>", cur_highs);
                end else begin
                    d = period_q.pop_front();
                    chk("period_highs", cur_highs, d);
                end
            end
            last_highs = cur_highs;
            n_starts++;
            cur_highs = (pwm_out === 1'b1) ? 1 : 0;
        end else if (edge_ena && pwm_out === 1'b1) begin
            cur_highs++;
        end
    endtask

    task automatic do_reset();
        sample_valid = 1'b0;
        underrun_clr = 1'b0;
        rst = 1'b0;
        #2;
        chk("rst_pwm_out", pwm_out, 0);
        chk("rst_period_start", period_start, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_sample_ready", sample_ready, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        m_cnt = 4'd0; m_duty = 4'd0; m_pend = 4'd0;
        m_full = 1'b0; m_pwm = 1'b0; m_und = 1'b0;
        exp_q.delete();
        period_q.delete();
        period_q.push_back(0);
        cur_highs = 0;
        last_highs = 0;
        n_starts = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Offer a sample until accepted; reports the number of stalled cycles.
    task automatic send(input logic [N-1:0] v, output int stalls);
        logic acc;
        sample_valid = 1'b1;
        sample_in = v;
        stalls = 0;
        acc = 1'b0;
        for (int i = 0; i < 64 && !acc; i++) begin
            acc = (sample_ready === 1'b1);
            step();
            if (!acc) stalls++;
        end
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: got no accept, expected accept of %0d", v);
        end
    endtask

    task automatic wait_start();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            step();
            seen = (period_start === 1'b1);
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_period_start: got timeout, expected pulse");
        end
    endtask

    task automatic test_reset();
        do_reset();
        ena = 1'b1;
        step();
        chk("first_period_start", period_start, 1);
    endtask

    task automatic test_stream();
        do_reset();
        ena = 1'b1;
        idle(16);
        chk("stream_first_underrun", underrun, 1);
        sample_valid = 1'b1;
        sample_in = 4'd5;
        wait_start();
        wait_start();
        wait_start();
        chk("stream_highs", last_highs, 5);
        wait_start();
        chk("stream_highs2", last_highs, 5);
        chk("stream_underrun_sticky", underrun, 1);
        underrun_clr = 1'b1;
        step();
        underrun_clr = 1'b0;
        chk("stream_underrun_cleared", underrun, 0);
        wait_start();
        chk("stream_no_underrun", underrun, 0);
        sample_valid = 1'b0;
    endtask

    task automatic test_extremes();
        int s;
        do_reset();
        ena = 1'b1;
        send(4'd0, s);
        send(4'd15, s);
        send(4'd15, s);
        sample_valid = 1'b0;
        chk("extreme_all_low", last_highs, 0);
        wait_start();
        chk("extreme_max", last_highs, 15);
        chk("extreme_no_underrun", underrun, 0);
    endtask

    task automatic test_back_to_back();
        int s;
        do_reset();
        ena = 1'b1;
        send(4'd3, s);
        chk("bp_stall_3", s, 0);
        chk("bp_ready_low", sample_ready, 0);
        send(4'd9, s);
        chk("bp_stall_9", s, 15);
        send(4'd12, s);
        chk("bp_stall_12", s, 15);
        sample_valid = 1'b0;
        chk("bp_period_3", last_highs, 3);
        wait_start();
        chk("bp_period_9", last_highs, 9);
        wait_start();
        chk("bp_period_12", last_highs, 12);
        chk("bp_underrun_after_drain", underrun, 1);
    endtask

    task automatic test_bypass();
        do_reset();
        ena = 1'b1;
        idle(15);
        sample_valid = 1'b1;
        sample_in = 4'd7;
        step();
        sample_valid = 1'b0;
        chk("bypass_underrun", underrun, 0);
        wait_start();
        chk("bypass_underrun_next", underrun, 0);
        wait_start();
        chk("bypass_highs", last_highs, 7);
    endtask

    task automatic test_underrun_clr();
        do_reset();
        ena = 1'b1;
        idle(15);
        underrun_clr = 1'b1;
        step();
        underrun_clr = 1'b0;
        chk("clr_vs_set", underrun, 1);
        underrun_clr = 1'b1;
        step();
        underrun_clr = 1'b0;
        chk("clr_alone", underrun, 0);
    endtask

    task automatic test_ena_toggle();
        logic held;
        do_reset();
        ena = 1'b1;
        sample_valid = 1'b1;
        sample_in = 4'd5;
        wait_start();
        wait_start();
        idle(2);
        held = pwm_out;
        chk("ena_pwm_high_before", held, 1);
        ena = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("ena_pwm_hold", pwm_out, held);
            chk("ena_no_period_start", period_start, 0);
        end
        ena = 1'b1;
        wait_start();
        chk("ena_total_highs", last_highs, 5);
    endtask

    task automatic test_async_reset();
        idle(1);
        chk("arst_pwm_before", pwm_out, 1);
        do_reset();
        ena = 1'b1;
        wait_start();
        wait_start();
        chk("arst_first_period_duty0", last_highs, 0);
        chk("arst_first_underrun", underrun, 1);
    endtask

    initial begin
        #2;
        test_reset();
        test_stream();
        test_extremes();
        test_back_to_back();
        test_bypass();
        test_underrun_clr();
        test_ena_toggle();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
